// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multicycle control sequencer with PC, wait-state memory handshake, branches and call/return
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   ir         instruction register contents
//   N, V, Z    datapath status flags
//   c_in       datapath C output (data address / BX target)
//   mem_ready  memory completes the current command this cycle
//   mem_cmd    01 READ, 10 NONE, 11 WRITE
//   mem_addr   PC during fetch, data_addr during load/store
//   pc         current PC
//   load_ir    IR capture strobe
//   readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel  datapath control
//   halted     in HALT
//   err        in ERR
module cpu_ctrl_seq #(
  parameter int ADDR_W = 9,
  parameter int unsigned RESET_PC = 0,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ir,
  input  logic              N,
  input  logic              V,
  input  logic              Z,
  input  logic [15:0]       c_in,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              load_ir,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic              halted,
  output logic              err
);
  localparam logic [1:0] CMD_READ = 2'b01, CMD_NONE = 2'b10, CMD_WRITE = 2'b11;
  typedef enum logic [4:0] {
    S_RST, S_IF, S_UPC, S_DEC, S_MOVI, S_MOVR_B, S_MOVR_C, S_ALU_B, S_ALU_A, S_ALU_S,
    S_ALU_C, S_WB, S_LDR_A, S_LDR_C, S_LDR_AD, S_LDR_M, S_STR_A, S_STR_C, S_STR_AD,
    S_STR_B, S_STR_C2, S_STR_M, S_BCC, S_BL, S_BX_B, S_BX_C, S_BX_P, S_HALT, S_ERR
  } state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] data_addr, sximm;
  logic [7:0] wcnt;
  logic [2:0] opcode, cond, rn, rd, rm;
  logic [1:0] op;
  logic addr_sel, cond_valid, cond_ok, timeout, mem_st, unused_bits;
  assign opcode = ir[15:13];
  assign op = ir[12:11];
  assign cond = ir[10:8];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign rm = ir[2:0];
  assign sximm = ADDR_W'($signed(ir[7:0]));
  assign unused_bits = ^c_in;
  assign mem_addr = addr_sel ? pc : data_addr;
  assign cond_valid = cond <= 3'd4;
  assign cond_ok = cond == 3'd0 ? 1'b1 :
                   cond == 3'd1 ? Z :
                   cond == 3'd2 ? !Z :
                   cond == 3'd3 ? N ^ V : (N ^ V) | Z;
  // wait budget is spent when this is the TIMEOUT-th consecutive not-ready cycle
  assign timeout = wcnt == 8'(TIMEOUT - 1);
  assign mem_st = state == S_IF || state == S_LDR_M || state == S_STR_M;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RST;
      pc <= ADDR_W'(RESET_PC);
      data_addr <= '0;
      wcnt <= '0;
    end else begin
      state <= nxt;
      // counter restarts whenever a memory state is (re)entered
      wcnt <= (mem_st && nxt == state) ? wcnt + 8'd1 : 8'd0;
      case (state)
        S_UPC: pc <= pc + ADDR_W'(1);
        S_BCC: if (cond_valid && cond_ok) pc <= pc + sximm;
        S_BL: pc <= pc + sximm;
        S_BX_P: pc <= c_in[ADDR_W-1:0];
        S_LDR_AD, S_STR_AD: data_addr <= c_in[ADDR_W-1:0];
        default: ;
      endcase
    end
  end
  always_comb begin
    nxt = state;
    mem_cmd = CMD_NONE;
    addr_sel = 1'b0;
    load_ir = 1'b0;
    readnum = 3'd0;
    writenum = 3'd0;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel = 1'b0;
    bsel = 1'b0;
    vsel = 2'b00;
    halted = 1'b0;
    err = 1'b0;
    case (state)
      S_RST: nxt = S_IF;
      S_IF: begin
        mem_cmd = CMD_READ;
        addr_sel = 1'b1;
        load_ir = mem_ready;
        nxt = mem_ready ? S_UPC : timeout ? S_ERR : S_IF;
      end
      S_UPC: nxt = S_DEC;
      S_DEC: case (opcode)
        3'b110: nxt = op == 2'b10 ? S_MOVI : op == 2'b00 ? S_MOVR_B : S_ERR;
        3'b101: nxt = S_ALU_B;
        3'b011: nxt = op == 2'b00 ? S_LDR_A : S_ERR;
        3'b100: nxt = op == 2'b00 ? S_STR_A : S_ERR;
        3'b001: nxt = op == 2'b00 ? S_BCC : S_ERR;
        3'b010: nxt = op == 2'b11 ? S_BL : op == 2'b00 ? S_BX_B : S_ERR;
        3'b111: nxt = S_HALT;
        default: nxt = S_ERR;
      endcase
      S_MOVI: begin
        write = 1'b1;
        writenum = rn;
        vsel = 2'b10;
        nxt = S_IF;
      end
      S_MOVR_B: begin
        readnum = rm;
        loadb = 1'b1;
        nxt = S_MOVR_C;
      end
      S_MOVR_C: begin
        asel = 1'b1;
        loadc = 1'b1;
        nxt = S_WB;
      end
      S_ALU_B: begin
        readnum = rm;
        loadb = 1'b1;
        nxt = S_ALU_A;
      end
      S_ALU_A: begin
        readnum = rn;
        loada = 1'b1;
        nxt = op == 2'b01 ? S_ALU_S : S_ALU_C;
      end
      S_ALU_S: begin
        loads = 1'b1;
        nxt = S_IF;
      end
      S_ALU_C: begin
        loadc = 1'b1;
        nxt = S_WB;
      end
      S_WB: begin
        write = 1'b1;
        writenum = rd;
        nxt = S_IF;
      end
      S_LDR_A, S_STR_A: begin
        readnum = rn;
        loada = 1'b1;
        nxt = state == S_LDR_A ? S_LDR_C : S_STR_C;
      end
      S_LDR_C, S_STR_C: begin
        bsel = 1'b1;
        loadc = 1'b1;
        nxt = state == S_LDR_C ? S_LDR_AD : S_STR_AD;
      end
      S_LDR_AD: nxt = S_LDR_M;
      S_STR_AD: nxt = S_STR_B;
      S_LDR_M: begin
        mem_cmd = CMD_READ;
        write = mem_ready;
        writenum = rd;
        vsel = 2'b11;
        nxt = mem_ready ? S_IF : timeout ? S_ERR : S_LDR_M;
      end
      S_STR_B: begin
        readnum = rd;
        loadb = 1'b1;
        nxt = S_STR_C2;
      end
      S_STR_C2: begin
        asel = 1'b1;
        loadc = 1'b1;
        nxt = S_STR_M;
      end
      S_STR_M: begin
        mem_cmd = CMD_WRITE;
        nxt = mem_ready ? S_IF : timeout ? S_ERR : S_STR_M;
      end
      S_BCC: nxt = cond_valid ? S_IF : S_ERR;
      S_BL: begin
        write = 1'b1;
        writenum = 3'd7;
        vsel = 2'b01;
        nxt = S_IF;
      end
      S_BX_B: begin
        readnum = rd;
        loadb = 1'b1;
        nxt = S_BX_C;
      end
      S_BX_C: begin
        asel = 1'b1;
        loadc = 1'b1;
        nxt = S_BX_P;
      end
      S_BX_P: nxt = S_IF;
      S_HALT: halted = 1'b1;
      S_ERR: err = 1'b1;
      default: nxt = S_ERR;
    endcase
  end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: directed self-checking bench for cpu_ctrl_seq
module tb_cpu_ctrl_seq;
  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] ir = '0, c_in = '0;
  logic N = 1'b0, V = 1'b0, Z = 1'b0, mem_ready = 1'b1;
  logic [1:0] mem_cmd, vsel;
  logic [8:0] mem_addr, pc;
  logic load_ir, write, loada, loadb, loadc, loads, asel, bsel, halted, err;
  logic [2:0] readnum, writenum;
  int checks = 0, failures = 0;
  cpu_ctrl_seq dut (
    .clk(clk), .reset(reset), .ir(ir), .N(N), .V(V), .Z(Z), .c_in(c_in),
    .mem_ready(mem_ready), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .pc(pc),
    .load_ir(load_ir), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .bsel(bsel), .vsel(vsel), .halted(halted), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [15:0] i);
    ir = i;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic bx(input logic [15:0] target);
    issue(16'h40E0);
    chk("bx_b_readnum", readnum, 7);
    chk("bx_b_loadb", loadb, 1);
    @(negedge clk);
    chk("bx_c_asel", asel, 1);
    c_in = target;
    @(negedge clk);
    @(negedge clk);
    chk("bx_pc", pc, target);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd", mem_cmd, 2'b10);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {halted, err, write, load_ir, loadb, loadc}, 0);
    chk("rst_vsel", vsel, 0);
    reset = 1'b1;
    ir = 16'hD105;
    @(negedge clk);
    chk("if_cmd", mem_cmd, 2'b01);
    chk("if_addr", mem_addr, 0);
    chk("if_load_ir", load_ir, 1);
    @(negedge clk);
    @(negedge clk);
    chk("dec_pc", pc, 1);
    @(negedge clk);
    chk("movi_wnum", writenum, 1);
    chk("movi_vsel", vsel, 2'b10);
    chk("movi_write", write, 1);
    @(negedge clk);
    ir = 16'hA902;
    mem_ready = 1'b0;
    #1 chk("wait1_load_ir", load_ir, 0);
    repeat (2) @(negedge clk);
    chk("wait3_cmd", mem_cmd, 2'b01);
    chk("wait3_load_ir", load_ir, 0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("wait4_load_ir", load_ir, 1);
    repeat (3) @(negedge clk);
    chk("alu_b_readnum", readnum, 2);
    chk("alu_b_loadb", loadb, 1);
    @(negedge clk);
    chk("alu_a", {readnum, loada}, {3'd1, 1'b1});
    @(negedge clk);
    chk("alu_s_loads", loads, 1);
    @(negedge clk);
    chk("cmp_pc", pc, 2);
    bx(16'd5);
    Z = 1'b1;
    issue(16'h21FD);
    chk("bcc_pc", pc, 6);
    @(negedge clk);
    chk("beq_taken_pc", pc, 3);
    bx(16'd5);
    Z = 1'b0;
    issue(16'h21FD);
    @(negedge clk);
    chk("beq_not_taken_pc", pc, 6);
    bx(16'd9);
    issue(16'h5804);
    chk("bl_pc", pc, 10);
    chk("bl_wnum", writenum, 7);
    chk("bl_vsel", vsel, 2'b01);
    chk("bl_write", write, 1);
    @(negedge clk);
    chk("bl_target", pc, 14);
    bx(16'd10);
    issue(16'h6140);
    chk("ldr_a", {readnum, loada}, {3'd1, 1'b1});
    @(negedge clk);
    chk("ldr_c", {bsel, loadc}, 2'b11);
    c_in = 16'h0140;
    repeat (2) @(negedge clk);
    chk("ldr_cmd", mem_cmd, 2'b01);
    chk("ldr_addr", mem_addr, 9'h140);
    chk("ldr_wb", {write, writenum, vsel}, {1'b1, 3'd2, 2'b11});
    @(negedge clk);
    chk("ldr_done_cmd", mem_cmd, 2'b01);
    issue(16'h8160);
    @(negedge clk);
    c_in = 16'h00A0;
    repeat (2) @(negedge clk);
    chk("str_b", {readnum, loadb}, {3'd3, 1'b1});
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("str_cmd", mem_cmd, 2'b11);
    chk("str_addr", mem_addr, 9'h0A0);
    @(negedge clk);
    chk("str_hold_cmd", mem_cmd, 2'b11);
    #2 reset = 1'b0;
    #1 chk("async_rst_cmd", mem_cmd, 2'b10);
    chk("async_rst_pc", pc, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(16'hE000);
    chk("halt", halted, 1);
    repeat (20) @(negedge clk);
    chk("halt_hold", {halted, err, mem_cmd}, {2'b10, 2'b10});
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("to_start_err", err, 0);
    repeat (14) @(negedge clk);
    chk("to_15_err", err, 0);
    chk("to_15_cmd", mem_cmd, 2'b01);
    @(negedge clk);
    chk("to_err", err, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
